// File: rtl/ili9341_parallel8.sv
// ili9341_parallel8 -- ILI9341 320x240 TFT driver over the 8080-style 8-bit bus.
//
// Sequence after reset: hold the panel reset low, wait, play the init command
// ROM (with long waits after software reset and sleep-out), then stream RGB565
// pixels, one per 4-clock slot, while the upstream asserts write.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   vblank                frame resync request, sampled at slot start
//   write                 pixel valid for the current slot, sampled at slot start
//   col_r/col_g/col_b     8-bit colour, sampled at slot start
//   lcd_rst/lcd_cs        panel reset / chip select (both active low)
//   lcd_rs                0 = command byte, 1 = data byte
//   lcd_wr                write strobe, the panel latches on its rising edge
//   lcd_rd                read strobe, tied high
//   data                  bus byte
//   initialized           high once the init ROM has been sent, until reset
//   hsync/vsync           one-clock end-of-line / end-of-frame pulses
//
// Handshake: the bus has no back-pressure. A byte is phase A (data/lcd_rs
// driven, lcd_wr=0) followed by phase B (lcd_wr=1, data/lcd_rs held), with no
// idle cycle between bytes. Upstream offers a pixel by holding write=1 at a
// slot start; a slot with write=0 sends nothing and leaves x/y untouched.
//
// Build option: define ILI9341_BGR_EN to program MADCTL with BGR colour order
// (0x28); by default MADCTL is 0x20 (row/column exchange, RGB order).
//
// The FSM state is held in state_q for hierarchical observation.

module ili9341_parallel8 #(
  parameter int RST_LOW_CYCLES    = 100,
  parameter int RST_WAIT_CYCLES   = 1200000,
  parameter int SLEEP_WAIT_CYCLES = 1200000,
  parameter int H_PIXELS          = 320,
  parameter int V_LINES           = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       write,
  input  logic [7:0] col_r,
  input  logic [7:0] col_g,
  input  logic [7:0] col_b,
  output logic       lcd_rst,
  output logic       lcd_cs,
  output logic       lcd_rs,
  output logic       lcd_wr,
  output logic       lcd_rd,
  output logic [7:0] data,
  output logic       initialized,
  output logic       hsync,
  output logic       vsync
);

`ifdef ILI9341_BGR_EN
  localparam logic [7:0] MADCTL = 8'h28;
`else
  localparam logic [7:0] MADCTL = 8'h20;
`endif

  localparam int ROM_LEN = 18;
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  typedef enum logic [1:0] {S_HW_RST, S_WAIT, S_INIT, S_STREAM} state_e;
  typedef enum logic [1:0] {M_IDLE, M_PIX, M_CMD} mode_e;

  // Init ROM entry: {wait code, dc, byte}. Wait code 1 = reset wait, 2 = sleep wait.
  function automatic logic [10:0] rom_entry(input logic [4:0] i);
    case (i)
      5'd0:    rom_entry = {2'd1, 1'b0, 8'h01};
      5'd1:    rom_entry = {2'd2, 1'b0, 8'h11};
      5'd2:    rom_entry = {2'd0, 1'b0, 8'h3A};
      5'd3:    rom_entry = {2'd0, 1'b1, 8'h55};
      5'd4:    rom_entry = {2'd0, 1'b0, 8'h36};
      5'd5:    rom_entry = {2'd0, 1'b1, MADCTL};
      5'd6:    rom_entry = {2'd0, 1'b0, 8'h29};
      5'd7:    rom_entry = {2'd0, 1'b0, 8'h2A};
      5'd8:    rom_entry = {2'd0, 1'b1, 8'h00};
      5'd9:    rom_entry = {2'd0, 1'b1, 8'h00};
      5'd10:   rom_entry = {2'd0, 1'b1, 8'h01};
      5'd11:   rom_entry = {2'd0, 1'b1, 8'h3F};
      5'd12:   rom_entry = {2'd0, 1'b0, 8'h2B};
      5'd13:   rom_entry = {2'd0, 1'b1, 8'h00};
      5'd14:   rom_entry = {2'd0, 1'b1, 8'h00};
      5'd15:   rom_entry = {2'd0, 1'b1, 8'h00};
      5'd16:   rom_entry = {2'd0, 1'b1, 8'hEF};
      default: rom_entry = {2'd0, 1'b0, 8'h2C};
    endcase
  endfunction

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          wait_sel_q, wait_sel_d;
  logic [4:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [1:0]    slot_q, slot_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    lo_q, lo_d;
  logic          lcd_rst_q, lcd_rst_d, lcd_cs_q, lcd_cs_d, lcd_rs_q, lcd_rs_d;
  logic          lcd_wr_q, lcd_wr_d, init_q, init_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic [7:0]    data_q, data_d;

  logic [10:0] ent;
  logic [31:0] wait_last;
  logic [7:0]  px_hi, px_lo;
  logic        unused_col;

  assign ent       = rom_entry(idx_q);
  assign wait_last = wait_sel_q ? 32'(SLEEP_WAIT_CYCLES - 1) : 32'(RST_WAIT_CYCLES - 1);
  assign px_hi     = {col_r[7:3], col_g[7:5]};
  assign px_lo     = {col_g[4:2], col_b[7:3]};
  // RGB565 drops the low colour bits.
  assign unused_col = &{1'b0, col_r[2:0], col_g[1:0], col_b[2:0]};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    wait_sel_d = wait_sel_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    x_d        = x_q;
    y_d        = y_q;
    lo_d       = lo_q;
    lcd_rst_d  = lcd_rst_q;
    lcd_cs_d   = lcd_cs_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_wr_d   = lcd_wr_q;
    data_d     = data_q;
    init_d     = init_q;
    hsync_d    = 1'b0;
    vsync_d    = 1'b0;
    case (state_q)
      S_HW_RST: begin
        if (cnt_q == 32'(RST_LOW_CYCLES - 1)) begin
          lcd_rst_d  = 1'b1;
          lcd_cs_d   = 1'b0;
          cnt_d      = '0;
          wait_sel_d = 1'b0;
          state_d    = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_INIT: begin
        if (idx_q == 5'(ROM_LEN)) begin
          // Clock after the last phase B: hand over to pixel streaming.
          init_d   = 1'b1;
          lcd_rs_d = 1'b1;
          slot_d   = '0;
          state_d  = S_STREAM;
        end else if (!phase_q) begin
          data_d   = ent[7:0];
          lcd_rs_d = ent[8];
          lcd_wr_d = 1'b0;
          phase_d  = 1'b1;
        end else begin
          lcd_wr_d = 1'b1;
          phase_d  = 1'b0;
          idx_d    = idx_q + 5'd1;
          if (ent[10:9] != 2'd0) begin
            cnt_d      = '0;
            wait_sel_d = ent[10];
            state_d    = S_WAIT;
          end
        end
      end
      default: begin  // S_STREAM
        slot_d = slot_q + 2'd1;
        case (slot_q)
          2'd0: begin
            mode_d = M_IDLE;
            // vblank wins over write; a resync at (0,0) would be a no-op.
            if (vblank && (x_q != '0 || y_q != '0)) begin
              mode_d   = M_CMD;
              data_d   = 8'h2C;
              lcd_rs_d = 1'b0;
              lcd_wr_d = 1'b0;
            end else if (write) begin
              mode_d   = M_PIX;
              data_d   = px_hi;
              lo_d     = px_lo;
              lcd_rs_d = 1'b1;
              lcd_wr_d = 1'b0;
            end
          end
          2'd1: begin
            lcd_wr_d = 1'b1;
            if (mode_q == M_CMD) begin
              x_d = '0;
              y_d = '0;
            end
          end
          2'd2: begin
            if (mode_q == M_PIX) begin
              data_d   = lo_q;
              lcd_wr_d = 1'b0;
            end
          end
          default: begin
            if (mode_q == M_PIX) begin
              lcd_wr_d = 1'b1;
              if (x_q == X_LAST) begin
                x_d     = '0;
                hsync_d = 1'b1;
                if (y_q == Y_LAST) begin
                  y_d     = '0;
                  vsync_d = 1'b1;
                end else begin
                  y_d = y_q + 1'b1;
                end
              end else begin
                x_d = x_q + 1'b1;
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HW_RST;
      mode_q     <= M_IDLE;
      cnt_q      <= '0;
      wait_sel_q <= 1'b0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
      slot_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      lo_q       <= '0;
      lcd_rst_q  <= 1'b0;
      lcd_cs_q   <= 1'b1;
      lcd_rs_q   <= 1'b1;
      lcd_wr_q   <= 1'b1;
      data_q     <= '0;
      init_q     <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      wait_sel_q <= wait_sel_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      lo_q       <= lo_d;
      lcd_rst_q  <= lcd_rst_d;
      lcd_cs_q   <= lcd_cs_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_wr_q   <= lcd_wr_d;
      data_q     <= data_d;
      init_q     <= init_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign lcd_rst     = lcd_rst_q;
  assign lcd_cs      = lcd_cs_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_wr      = lcd_wr_q;
  assign lcd_rd      = 1'b1;
  assign data        = data_q;
  assign initialized = init_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_ili9341_parallel8.sv
// Testbench for ili9341_parallel8 with a small panel (4x3) and short waits.
// Stimulus pushes expected bus bytes {vsync, hsync, rs, data} into exp_q; a
// monitor pops one entry at every lcd_wr rising edge and compares.

module tb_ili9341_parallel8;

  localparam int H = 4;
  localparam int V = 3;

`ifdef ILI9341_BGR_EN
  localparam logic [7:0] EXP_MADCTL = 8'h28;
`else
  localparam logic [7:0] EXP_MADCTL = 8'h20;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblank = 1'b0;
  logic       write = 1'b0;
  logic [7:0] col_r = '0, col_g = '0, col_b = '0;
  logic       lcd_rst, lcd_cs, lcd_rs, lcd_wr, lcd_rd;
  logic [7:0] data;
  logic       initialized, hsync, vsync;

  ili9341_parallel8 #(
    .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(8), .SLEEP_WAIT_CYCLES(8),
    .H_PIXELS(H), .V_LINES(V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .write(write),
    .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .lcd_rst(lcd_rst), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr),
    .lcd_rd(lcd_rd), .data(data), .initialized(initialized),
    .hsync(hsync), .vsync(vsync)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int last_rise_cyc = 0;
  int hs_cnt = 0;
  int vs_cnt = 0;
  int p = 0;  // pixels sent since the last resync (model position)

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_wr = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!prev_wr && lcd_wr) begin
        rise_cnt++;
        last_rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got rs=%0b data=0x%0h expected no write", lcd_rs, data);
        end else begin
          check("bus_byte", {vsync, hsync, lcd_rs, data}, exp_q.pop_front());
        end
      end else begin
        check("no_stray_sync", {vsync, hsync}, 2'b00);
      end
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
    end
    prev_wr = lcd_wr;
  end

  // ---------------- reference model / driver ----------------
  function automatic void push_byte(input bit dc, input logic [7:0] b, input bit hs, input bit vs);
    exp_q.push_back({vs, hs, dc, b});
  endfunction

  // One 4-clock pixel slot, starting at a negedge just before the slot-start edge.
  task automatic slot(input bit w, input bit v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    int x, y;
    logic [7:0] hi, lo;
    write = w; vblank = v; col_r = r; col_g = g; col_b = b;
    if (v && (p % (H * V)) != 0) begin
      push_byte(1'b0, 8'h2C, 1'b0, 1'b0);
      p = 0;
    end else if (w) begin
      x  = p % H;
      y  = (p / H) % V;
      hi = ((r >> 3) << 3) | (g >> 5);
      lo = (((g >> 2) & 8'h07) << 5) | (b >> 3);
      push_byte(1'b1, hi, 1'b0, 1'b0);
      push_byte(1'b1, lo, x == H - 1, (x == H - 1) && (y == V - 1));
      p++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic rand_slot(input bit w, input bit v);
    slot(w, v, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, t1, t2, r0, h0, v0;
    logic [7:0] init_seq[18];
    bit         init_dc[18];
    init_seq = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, EXP_MADCTL, 8'h29, 8'h2A, 8'h00,
                 8'h00, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h2C};
    init_dc  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    // Reset values; write/vblank are held high to show they are ignored pre-init.
    write = 1'b1; vblank = 1'b1; col_r = 8'hA5; col_g = 8'h5A; col_b = 8'h3C;
    repeat (3) @(negedge clk);
    check("rst_lcd_rst", lcd_rst, 1'b0);
    check("rst_lcd_cs", lcd_cs, 1'b1);
    check("rst_lcd_rs", lcd_rs, 1'b1);
    check("rst_lcd_wr", lcd_wr, 1'b1);
    check("rst_lcd_rd", lcd_rd, 1'b1);
    check("rst_data", data, 8'h00);
    check("rst_initialized", initialized, 1'b0);
    check("rst_hsync", hsync, 1'b0);
    check("rst_vsync", vsync, 1'b0);

    for (int i = 0; i < 18; i++) push_byte(init_dc[i], init_seq[i], 1'b0, 1'b0);

    // Panel reset low for exactly 4 clocks after release.
    rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (lcd_rst) break;
      check("cs_high_in_hw_reset", lcd_cs, 1'b1);
    end
    check("lcd_rst_low_clocks", n, 4);
    check("cs_low_after_hw_reset", lcd_cs, 1'b0);

    // Wait for init to complete.
    n = 0;
    while (!initialized && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("init_timeout", initialized, 1'b1);
    #1;
    check("init_bytes_left", exp_q.size(), 0);
    check("init_rise_latency", cyc - last_rise_cyc, 1);
    check("rs_after_init", lcd_rs, 1'b1);

    // Pixel conversion and 4 clocks per pixel.
    slot(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF);
    #1 t1 = last_rise_cyc;
    rand_slot(1'b1, 1'b0);
    #1 t2 = last_rise_cyc;
    check("pixel_period", t2 - t1, 4);

    // Resync, then one full frame of 12 pixels.
    rand_slot(1'b0, 1'b1);
    h0 = hs_cnt; v0 = vs_cnt;
    for (int i = 0; i < 12; i++) rand_slot(1'b1, 1'b0);
    #1;
    check("frame_hsync_count", hs_cnt - h0, 3);
    check("frame_vsync_count", vs_cnt - v0, 1);

    // Stall: no strobes for 3 idle slots.
    r0 = rise_cnt;
    for (int i = 0; i < 3; i++) rand_slot(1'b0, 1'b0);
    #1 check("stall_no_writes", rise_cnt - r0, 0);

    // vblank at (0,0) is ignored, then resync from x=2.
    rand_slot(1'b1, 1'b1);
    rand_slot(1'b1, 1'b0);
    rand_slot(1'b1, 1'b1);
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) rand_slot(1'b1, 1'b0);
    #1 check("resync_line_hsync", hs_cnt - h0, 1);

    // Random traffic.
    for (int i = 0; i < 80; i++)
      rand_slot($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of a pixel (hi byte in phase A).
    write = 1'b1; vblank = 1'b0; col_r = 8'h12; col_g = 8'h34; col_b = 8'h56;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_lcd_rst", lcd_rst, 1'b0);
    check("midrst_lcd_cs", lcd_cs, 1'b1);
    check("midrst_lcd_rs", lcd_rs, 1'b1);
    check("midrst_lcd_wr", lcd_wr, 1'b1);
    check("midrst_data", data, 8'h00);
    check("midrst_initialized", initialized, 1'b0);
    check("midrst_sync", {vsync, hsync}, 2'b00);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ili9341_parallel8.md
Name: ili9341_parallel8

Overview:
- Drives an ILI9341 320x240 TFT over the 8080-style 8-bit parallel bus.
- After reset it runs the panel hardware-reset and init command sequence, then streams RGB565 pixels, one per 4 clocks, while the upstream asserts write.
- Sits between the video pipeline (vpu colour output plus pixel counter) and the LCD pins.
- Reports initialized, and end-of-line/end-of-frame pulses for upstream counter resync.

Parameters:
- RST_LOW_CYCLES, default 100: clocks LCD reset held low.
- RST_WAIT_CYCLES, default 1200000: clocks waited after reset release and after software reset (0x01).
- SLEEP_WAIT_CYCLES, default 1200000: clocks waited after sleep-out (0x11).
- H_PIXELS, default 320: pixels per line.
- V_LINES, default 240: lines per frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vblank  in  1  frame resync request.
- write  in  1  pixel valid for the current pixel slot.
- col_r  in  8  red, sampled at slot start.
- col_g  in  8  green, sampled at slot start.
- col_b  in  8  blue, sampled at slot start.
- lcd_rst  out  1  panel reset, active low.
- lcd_cs  out  1  chip select, active low.
- lcd_rs  out  1  D/C select: 0 = command, 1 = data.
- lcd_wr  out  1  write strobe; panel latches on rising edge.
- lcd_rd  out  1  read strobe, constant 1.
- data  out  8  bus data.
- initialized  out  1  init sequence complete; stays high until reset.
- hsync  out  1  one-clock end-of-line pulse.
- vsync  out  1  one-clock end-of-frame pulse.

Behaviour:
- Reset values (async, rst_n=0): lcd_rst=0, lcd_cs=1, lcd_rs=1, lcd_wr=1, lcd_rd=1, data=0, initialized=0, hsync=0, vsync=0, x=0, y=0. Reset mid-operation aborts immediately and restarts from HW_RST.
- Byte write is 2 clocks:
  - Phase A: drive data/lcd_rs, lcd_wr=0.
  - Phase B: lcd_wr=1; data/lcd_rs held.
  - No idle cycle between consecutive bytes.
- States:
  - HW_RST: lcd_rst=0 for RST_LOW_CYCLES, then lcd_rst=1 and lcd_cs=0.
  - WAIT: RST_WAIT_CYCLES.
  - INIT: walks a fixed ROM of {dc, byte, wait} entries.
  - STREAM.
- Init ROM, in order:
  - cmd 0x01, then wait RST_WAIT_CYCLES.
  - cmd 0x11, then wait SLEEP_WAIT_CYCLES.
  - cmd 0x3A, data 0x55 (16 bpp).
  - cmd 0x36, data MADCTL (see Optional Feature).
  - cmd 0x29.
  - cmd 0x2A, data 0x00 0x00 0x01 0x3F.
  - cmd 0x2B, data 0x00 0x00 0x00 0xEF.
  - cmd 0x2C.
- On the clock after the final 0x2C phase B: initialized=1, enter STREAM, lcd_rs=1.
- STREAM pixel slots are 4 clocks long.
  - At slot start with write=1: convert r,g,b to RGB565 and send hi={r[7:3],g[7:5]} then lo={g[4:2],b[7:3]}.
  - With write=0: slot idles, lcd_wr stays 1, counters hold.
- Counters advance after each sent pixel.
  - x wraps at H_PIXELS-1 to 0 and increments y.
  - y wraps at V_LINES-1 to 0.
- Sync pulses: hsync=1 for one clock, coincident with lo-byte phase B, when the pixel was at x=H_PIXELS-1. vsync likewise when additionally y=V_LINES-1.
- vblank=1 at a slot start while (x,y)!=(0,0):
  - Send cmd 0x2C (2 clocks), then zero x and y.
  - vblank has priority over write in that slot; the pixel is not sent.
  - vblank at (0,0) is ignored.
- vblank and write are ignored before initialized=1.

Optional Feature:
- ILI9341_BGR_EN defined: MADCTL data = 0x28 (row/column exchange + BGR order).
- Not defined: MADCTL data = 0x20 (row/column exchange, RGB order).
- All else identical.

Test Plan:
- Parameters RST_LOW_CYCLES=4, RST_WAIT_CYCLES=8, SLEEP_WAIT_CYCLES=8, H_PIXELS=4, V_LINES=3.
- Reset: hold rst_n=0 -> all outputs at reset values; release -> lcd_rst low exactly 4 clocks, then lcd_cs=0.
- Init capture, sampling data/lcd_rs at each lcd_wr rising edge -> exact sequence 01c 11c 3Ac 55d 36c 28d(BGR_EN)/20d 29c 2Ac 00d 00d 01d 3Fd 2Bc 00d 00d 00d EFd 2Cc; initialized rises one clock after the last byte.
- Pixel conversion, write=1 with r=0xFF g=0x00 b=0xFF -> bytes 0xF8, 0x1F with lcd_rs=1, 4 clocks per pixel.
- Counters, write held 1 for 12 pixels -> hsync pulses after pixels 4, 8, 12; single vsync after pixel 12; no other pulses.
- Stall and resync:
  - write=0 for 3 slots -> no lcd_wr edges, counters frozen.
  - vblank=1 at x=2 -> cmd 0x2C with lcd_rs=0, next pixel counted as x=0,y=0.
  - Assert rst_n=0 mid-pixel -> immediate reset values.
